// File: rtl/blink_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the mode and state encodings, the per-mode seeds and the rate field width.
package blink_pkg;

    localparam int RATE_W = 3;

    typedef enum logic [1:0] {
        MODE_COUNT    = 2'd0,
        MODE_WALK     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] SEED_COUNT    = 8'h00;
    localparam logic [7:0] SEED_WALK     = 8'h01;
    localparam logic [7:0] SEED_PINGPONG = 8'h01;
    localparam logic [7:0] SEED_BLINK    = 8'h00;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [7:0] mode_seed(input mode_e m);
        logic [7:0] s;
        case (m)
            MODE_COUNT:    s = SEED_COUNT;
            MODE_WALK:     s = SEED_WALK;
            MODE_PINGPONG: s = SEED_PINGPONG;
            default:       s = SEED_BLINK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/blink_sequencer_if.sv
// Host command / LED status bundle for blink_sequencer (pause only with BLINK_SEQ_PAUSE_EN).
// master = host side, slave = sequencer side.
interface blink_sequencer_if;
    import blink_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [RATE_W-1:0] cmd_rate;
    logic [7:0]        cmd_steps;
    logic              abort;
    logic              busy;
    logic              done;
    logic              tick;
    logic [7:0]        q;
`ifdef BLINK_SEQ_PAUSE_EN
    logic              pause;

    modport master (
        output cmd_valid, cmd_mode, cmd_rate, cmd_steps, abort, pause,
        input  cmd_ready, busy, done, tick, q
    );
    modport slave (
        input  cmd_valid, cmd_mode, cmd_rate, cmd_steps, abort, pause,
        output cmd_ready, busy, done, tick, q
    );
`else
    modport master (
        output cmd_valid, cmd_mode, cmd_rate, cmd_steps, abort,
        input  cmd_ready, busy, done, tick, q
    );
    modport slave (
        input  cmd_valid, cmd_mode, cmd_rate, cmd_steps, abort,
        output cmd_ready, busy, done, tick, q
    );
`endif

endinterface

// File: rtl/blink_tick_gen.sv
// Step divider: counts 0..period_m1 while enabled, tick_o high in the terminal cycle.
// Latency: tick is combinational from the count; wraps to 0 on the tick edge.
// Backpressure: enable_i low freezes the count and suppresses tick_o.
module blink_tick_gen #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rst1,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] period_m1_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == period_m1_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst1) begin
        if (rst1) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blink_sequencer.sv
// LED pattern sequencer: runs a latched mode/rate/step-count command on the 8-bit LED bus.
// Latency: busy and seed one cycle after accept; done one cycle after the final tick.
// Backpressure: cmd_ready only in IDLE; optional BLINK_SEQ_PAUSE_EN adds a pause input.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CLK_DIV = 25000000,
    parameter int DIV_W   = 25
) (
    input  logic          clk,
    input  logic          rst1,
    blink_sequencer_if.slave bus
);

    localparam logic [31:0] CLK_DIV_U = 32'(CLK_DIV);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] pm1_q, pm1_d;
    logic [7:0]       steps_q, steps_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic             dir_q, dir_d;
    logic [7:0]       q_q, q_d;

    logic [31:0]      rate_div;
    logic [DIV_W-1:0] pm1_new;
    logic [7:0]       q_step;
    logic             dir_step;
    logic             clear;
    logic             enable;
    logic             tick;
    logic             pause_w;

`ifdef BLINK_SEQ_PAUSE_EN
    assign pause_w = bus.pause;
`else
    assign pause_w = 1'b0;
`endif

    // Store period-1 so the divider compare never needs a wider-than-DIV_W value.
    assign rate_div = CLK_DIV_U >> bus.cmd_rate;
    assign pm1_new  = (rate_div <= 32'd1) ? '0 : DIV_W'(rate_div - 32'd1);

    // Abort wins over a coinciding tick, so the divider is held off on that edge too.
    assign enable = (state_q == RUN) && !bus.abort && !pause_w;

    blink_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk        (clk),
        .rst1       (rst1),
        .clear_i    (clear),
        .enable_i   (enable),
        .period_m1_i(pm1_q),
        .tick_o     (tick)
    );

    always_comb begin
        q_step   = q_q;
        dir_step = dir_q;
        case (mode_q)
            MODE_COUNT: q_step = q_q + 8'd1;
            MODE_WALK:  q_step = {q_q[6:0], q_q[7]};
            MODE_PINGPONG: begin
                q_step = (dir_q == DIR_LEFT) ? {q_q[6:0], 1'b0} : {1'b0, q_q[7:1]};
                if (q_step == 8'h80) begin
                    dir_step = DIR_RIGHT;
                end else if (q_step == 8'h01) begin
                    dir_step = DIR_LEFT;
                end
            end
            default:    q_step = ~q_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pm1_d      = pm1_q;
        steps_d    = steps_q;
        step_cnt_d = step_cnt_q;
        dir_d      = dir_q;
        q_d        = q_q;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d    = RUN;
                    mode_d     = mode_e'(bus.cmd_mode);
                    pm1_d      = pm1_new;
                    steps_d    = bus.cmd_steps;
                    step_cnt_d = '0;
                    dir_d      = DIR_LEFT;
                    q_d        = mode_seed(mode_e'(bus.cmd_mode));
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    step_cnt_d = step_cnt_q + 8'd1;
                    q_d        = q_step;
                    dir_d      = dir_step;
                    if ((steps_q != 8'd0) && (step_cnt_d == steps_q)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst1) begin
        if (rst1) begin
            state_q    <= IDLE;
            mode_q     <= MODE_COUNT;
            pm1_q      <= '0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            dir_q      <= DIR_LEFT;
            q_q        <= 8'h00;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pm1_q      <= pm1_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            dir_q      <= dir_d;
            q_q        <= q_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.tick      = tick;
    assign bus.q         = q_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomized bench for blink_sequencer with CLK_DIV=8; expected LED values come from
// closed-form pattern arithmetic (k steps after seed) and a per-cycle tick schedule.
module tb_blink_sequencer;

    localparam int CLK_DIV = 8;
    localparam int DIV_W   = 4;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    blink_sequencer_if bus();

    blink_sequencer #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst1(rst1),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_q   = 8'h00;

    // LED value after k pattern steps from the mode's seed.
    function automatic logic [7:0] pat(input int mode, input int k);
        int ph;
        int idx;
        case (mode)
            0: return 8'(k % 256);
            1: return 8'(1 << (k % 8));
            2: begin
                ph  = k % 14;
                idx = (ph <= 7) ? ph : 14 - ph;
                return 8'(1 << idx);
            end
            default: return ((k % 2) == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic int period_of(input int rate);
        int p;
        p = CLK_DIV >> rate;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic set_pause(input bit v);
`ifdef BLINK_SEQ_PAUSE_EN
        bus.pause = v;
`else
        if (v) $display("pause requested without BLINK_SEQ_PAUSE_EN");
`endif
    endtask

    // IDLE cycles with random fields and abort: nothing may change.
    task automatic idle_check(input string name, input int n);
        logic [10:0] obs;
        logic [10:0] exp_v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.cmd_mode  = 2'($urandom);
            bus.cmd_rate  = 3'($urandom);
            bus.cmd_steps = 8'($urandom);
            bus.abort     = 1'($urandom);
            #1;
            obs   = {bus.q, bus.busy, bus.done, bus.cmd_ready};
            exp_v = {last_q, 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL %s idle q/busy/done/rdy=%h expected %h", name, obs, exp_v);
            end
            checks++;
            if (bus.tick !== 1'b0) begin
                failures++;
                $display("FAIL %s idle tick=%b expected 0", name, bus.tick);
            end
        end
        bus.abort = 1'b0;
    endtask

    // Issue one command and check every cycle of its run plus the DONE/abort-exit cycle.
    task automatic run_seq(input string name, input int mode, input int rate, input int steps,
                           input int abort_at, input int pause_from, input int pause_len,
                           input bit hold, input int budget);
        int          p;
        int          a;
        int          k;
        bit          fin;
        bit          ab;
        bit          pz;
        bit          exp_tick;
        logic [10:0] obs;
        logic [10:0] exp_v;
        p   = period_of(rate);
        a   = 0;
        k   = 0;
        fin = 1'b0;
        ab  = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 2'(mode);
        bus.cmd_rate  = 3'(rate);
        bus.cmd_steps = 8'(steps);
        bus.abort     = 1'b0;
        set_pause(1'b0);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept cmd_ready=%b expected 1", name, bus.cmd_ready);
        end
        for (int c = 1; c <= budget && !fin; c++) begin
            @(negedge clk);
            if (hold) begin
                bus.cmd_mode  = 2'($urandom);
                bus.cmd_rate  = 3'($urandom);
                bus.cmd_steps = 8'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            ab = (c == abort_at);
            pz = (pause_len > 0) && (c >= pause_from) && (c < pause_from + pause_len);
            bus.abort = ab;
            set_pause(pz);
            #1;
            obs   = {bus.q, bus.busy, bus.done, bus.cmd_ready};
            exp_v = {pat(mode, k), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL %s cyc%0d q/busy/done/rdy=%h expected %h", name, c, obs, exp_v);
            end
            exp_tick = 1'b0;
            if (!ab) begin
                if (!pz) begin
                    a++;
                    exp_tick = ((a % p) == 0);
                end
                checks++;
                if (bus.tick !== exp_tick) begin
                    failures++;
                    $display("FAIL %s cyc%0d tick=%b expected %b", name, c, bus.tick, exp_tick);
                end
                if (exp_tick) k++;
            end
            if (ab || (exp_tick && steps != 0 && k == steps)) fin = 1'b1;
        end
        if (!fin) begin
            failures++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        set_pause(1'b0);
        if (!hold) bus.cmd_valid = 1'b0;
        #1;
        obs   = {bus.q, bus.busy, bus.done, bus.cmd_ready};
        exp_v = {pat(mode, k), 1'b0, !ab, ab};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s exit q/busy/done/rdy=%h expected %h", name, obs, exp_v);
        end
        checks++;
        if (bus.tick !== 1'b0) begin
            failures++;
            $display("FAIL %s exit tick=%b expected 0", name, bus.tick);
        end
        last_q = pat(mode, k);
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 2'd0;
        bus.cmd_rate  = 3'd0;
        bus.cmd_steps = 8'd0;
        bus.abort     = 1'b0;
        set_pause(1'b0);
        #23;
        obs = {bus.q, bus.busy, bus.done, bus.cmd_ready};
        checks++;
        if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_hold q/busy/done/rdy=%h expected %h", obs, {8'h00, 3'b001});
        end
        rst1 = 1'b0;
        last_q = 8'h00;
        idle_check("reset_idle", 4);
    endtask

    task automatic test_reset_mid_run();
        logic [10:0] obs;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 2'd3;
        bus.cmd_rate  = 3'd3;
        bus.cmd_steps = 8'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst1 = 1'b1;
        #1;
        obs = {bus.q, bus.busy, bus.done, bus.cmd_ready};
        checks++;
        if (obs !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid q/busy/done/rdy=%h expected %h", obs, {8'h00, 3'b001});
        end
        checks++;
        if (bus.tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid tick=%b expected 0", bus.tick);
        end
        #1 rst1 = 1'b0;
        last_q = 8'h00;
        idle_check("reset_mid_idle", 3);
    endtask

    task automatic test_count();
        run_seq("count_r1_s3", 0, 1, 3, 0, 0, 0, 1'b0, 3 * 4 + 4);
        idle_check("count_hold", 3);
    endtask

    task automatic test_pingpong();
        run_seq("pingpong_r3_s16", 2, 3, 16, 0, 0, 0, 1'b0, 20);
        idle_check("pingpong_hold", 2);
    endtask

    task automatic test_abort();
        int r;
        int p;
        r = $urandom_range(0, 3);
        p = period_of(r);
        run_seq("walk_abort9", 1, r, 0, 9 * p + 1, 0, 0, 1'b0, 9 * p + 3);
        idle_check("walk_abort_hold", 3);
        run_seq("abort_final", $urandom_range(0, 3), 1, 4, 16, 0, 0, 1'b0, 20);
        idle_check("abort_final_hold", 2);
    endtask

    task automatic test_wrap();
        run_seq("count_wrap", 0, 3, 0, 258, 0, 0, 1'b0, 260);
        run_seq("rate7", $urandom_range(0, 3), 7, $urandom_range(1, 20), 0, 0, 0, 1'b0, 24);
    endtask

    task automatic test_back_to_back();
        run_seq("held_valid", 0, 2, 5, 0, 0, 0, 1'b1, 5 * 2 + 4);
        run_seq("after_held", 1, 3, 4, 0, 0, 0, 1'b0, 8);
        idle_check("after_held_idle", 2);
    endtask

    task automatic test_random();
        int m;
        int r;
        int s;
        for (int i = 0; i < 6; i++) begin
            m = $urandom_range(0, 3);
            r = $urandom_range(0, 7);
            s = $urandom_range(1, 10);
            run_seq("random", m, r, s, 0, 0, 0, 1'b0, s * period_of(r) + 4);
        end
    endtask

`ifdef BLINK_SEQ_PAUSE_EN
    task automatic test_pause();
        run_seq("pause_blink", 3, 0, 3, 0, 4, 10, 1'b0, 3 * 8 + 10 + 4);
        run_seq("pause_abort", 0, 1, 0, 7, 5, 6, 1'b0, 10);
        idle_check("pause_idle", 2);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count();
        test_pingpong();
        test_abort();
        test_wrap();
        test_back_to_back();
        test_random();
`ifdef BLINK_SEQ_PAUSE_EN
        test_pause();
`endif
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
